// File: rtl/descriptor_dispatcher_pkg.sv
// rtl/descriptor_dispatcher_pkg.sv - descriptor layout and dispatcher FSM encoding
//
// Package dispatcher_pkg: bit positions of the job fields inside a 1024-bit
// descriptor, the NOP opcode, and the dispatcher state type.
// No ports.
package dispatcher_pkg;

  localparam int DSC_W     = 1024;

  localparam int OPC_LSB   = 0;
  localparam int OPC_MSB   = 7;
  localparam int SRC_LSB   = 64;
  localparam int SRC_MSB   = 127;
  localparam int DST_LSB   = 128;
  localparam int DST_MSB   = 191;
  localparam int LEN_LSB   = 192;
  localparam int LEN_MSB   = 223;
  localparam int PNUM_LSB  = 992;
  localparam int PNUM_MSB  = 1000;
  // Bits above the process number must be zero in a well-formed descriptor.
  localparam int RSVD_LSB  = 1001;
  localparam int RSVD_MSB  = 1023;

  localparam logic [7:0] OPC_NOP = 8'h00;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2
  } state_t;

endpackage

// File: rtl/descriptor_dispatcher_rr_pick.sv
// rtl/descriptor_dispatcher_rr_pick.sv - combinational round-robin priority selector
//
// Module rr_pick: grants the first set bit of ready, searching upward from
// index start and wrapping modulo N.
// Ports:
//   ready [N-1:0]     in   request vector
//   start [PTR_W-1:0] in   highest-priority index (must be < N)
//   grant [N-1:0]     out  one-hot grant, 0 when nothing is ready
//   found             out  some bit of ready was set
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     ready,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic             found
);

  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so start+i can exceed N before the wrap subtract.
      pos = {1'b0, start} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(N)) pos = pos - (PTR_W+1)'(N);
      idx = pos[PTR_W-1:0];
      if (!found && ready[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/descriptor_dispatcher.sv
// rtl/descriptor_dispatcher.sv - parses descriptors and issues jobs to engines round-robin
//
// Pulls descriptors from a first-word-fall-through FIFO, stages the job
// fields, and offers each job to one ready engine chosen round-robin.
// Counts accepted jobs, completion pulses and outstanding work.
// Optional macro DISPATCH_ERR_CHECK_EN: drop descriptors with zero length or
// nonzero reserved bits and flag them on the sticky err_o.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en_i                        allow new descriptor pulls
//   dsc_data_i, dsc_ready_i     FIFO head word and non-empty flag
//   dsc_pull_o                  pop FIFO head this cycle
//   job_valid_o / job_ready_i   one-hot offer / per-engine accept
//   job_opcode_o .. job_pnum_o  staged job fields
//   eng_done_i                  per-engine completion pulses
//   dispatched_o, completed_o   wrapping job counters
//   busy_o                      staging occupied or jobs outstanding
//   err_o                       sticky descriptor error
module descriptor_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [DSC_W-1:0]       dsc_data_i,
  input  logic                   dsc_ready_i,
  output logic                   dsc_pull_o,
  output logic [NUM_ENGINES-1:0] job_valid_o,
  input  logic [NUM_ENGINES-1:0] job_ready_i,
  output logic [7:0]             job_opcode_o,
  output logic [63:0]            job_src_o,
  output logic [63:0]            job_dst_o,
  output logic [31:0]            job_len_o,
  output logic [8:0]             job_pnum_o,
  input  logic [NUM_ENGINES-1:0] eng_done_i,
  output logic [CNT_WIDTH-1:0]   dispatched_o,
  output logic [CNT_WIDTH-1:0]   completed_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int PTR_W = $clog2(NUM_ENGINES);
  localparam int PC_W  = 4;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, grant_idx_q, grant_idx;
  logic [NUM_ENGINES-1:0] job_valid_q, grant;
  logic                   found, pull, load_offer, accept, desc_bad;
  logic [7:0]             opc_q;
  logic [63:0]            src_q, dst_q;
  logic [31:0]            len_q;
  logic [8:0]             pnum_q;
  logic [CNT_WIDTH-1:0]   dispatched_q, completed_q;
  logic [OUT_WIDTH-1:0]   outstanding_q, out_d;
  logic [OUT_WIDTH:0]     out_sum, out_diff;
  logic [PC_W-1:0]        done_cnt;
  logic                   busy_q;
  logic                   unused_dsc_bits;

  rr_pick #(.N(NUM_ENGINES), .PTR_W(PTR_W)) u_rr_pick (
    .ready (job_ready_i),
    .start (rr_ptr_q),
    .grant (grant),
    .found (found)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

`ifdef DISPATCH_ERR_CHECK_EN
  logic rsvd_nz_q, err_q;
  assign desc_bad        = (len_q == 32'd0) | rsvd_nz_q;
  assign err_o           = err_q;
  assign unused_dsc_bits = ^{dsc_data_i[SRC_LSB-1:OPC_MSB+1], dsc_data_i[PNUM_LSB-1:LEN_MSB+1]};
`else
  assign desc_bad        = 1'b0;
  assign err_o           = 1'b0;
  assign unused_dsc_bits = ^{dsc_data_i[SRC_LSB-1:OPC_MSB+1], dsc_data_i[PNUM_LSB-1:LEN_MSB+1],
                             dsc_data_i[RSVD_MSB:RSVD_LSB]};
`endif

  always_comb begin
    state_d    = state_q;
    pull       = 1'b0;
    load_offer = 1'b0;
    accept     = 1'b0;
    case (state_q)
      EMPTY: begin
        pull = en_i & dsc_ready_i;
        if (pull) state_d = SELECT;
      end
      SELECT: begin
        if (opc_q == OPC_NOP || desc_bad) begin
          state_d = EMPTY;
        end else if (found) begin
          load_offer = 1'b1;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        // The offer is held regardless of en_i; en_i only gates the refill.
        if ((job_valid_q & job_ready_i) != '0) begin
          accept  = 1'b1;
          pull    = en_i & dsc_ready_i;
          state_d = pull ? SELECT : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outstanding count nets accept against done pulses, clamped at both ends.
  always_comb begin
    done_cnt = PC_W'($countones(eng_done_i));
    out_sum  = {1'b0, outstanding_q} + (OUT_WIDTH+1)'(accept);
    out_diff = '0;
    out_d    = '0;
    if (out_sum >= (OUT_WIDTH+1)'(done_cnt)) begin
      out_diff = out_sum - (OUT_WIDTH+1)'(done_cnt);
      out_d    = out_diff[OUT_WIDTH] ? '1 : out_diff[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      job_valid_q   <= '0;
      opc_q         <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      pnum_q        <= '0;
      dispatched_q  <= '0;
      completed_q   <= '0;
      outstanding_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      completed_q   <= completed_q + CNT_WIDTH'(done_cnt);
      outstanding_q <= out_d;
      busy_q        <= (state_d != EMPTY) | (out_d != '0);
      if (pull) begin
        opc_q  <= dsc_data_i[OPC_MSB:OPC_LSB];
        src_q  <= dsc_data_i[SRC_MSB:SRC_LSB];
        dst_q  <= dsc_data_i[DST_MSB:DST_LSB];
        len_q  <= dsc_data_i[LEN_MSB:LEN_LSB];
        pnum_q <= dsc_data_i[PNUM_MSB:PNUM_LSB];
      end
      if (load_offer) begin
        job_valid_q <= grant;
        grant_idx_q <= grant_idx;
      end else if (accept) begin
        job_valid_q <= '0;
      end
      if (accept) begin
        dispatched_q <= dispatched_q + CNT_WIDTH'(1);
        rr_ptr_q     <= (grant_idx_q == PTR_W'(NUM_ENGINES-1)) ? '0 : grant_idx_q + PTR_W'(1);
      end
    end
  end

`ifdef DISPATCH_ERR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsvd_nz_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (pull) rsvd_nz_q <= |dsc_data_i[RSVD_MSB:RSVD_LSB];
      if (state_q == SELECT && opc_q != OPC_NOP && desc_bad) err_q <= 1'b1;
    end
  end
`endif

  assign dsc_pull_o   = pull;
  assign job_valid_o  = job_valid_q;
  assign job_opcode_o = opc_q;
  assign job_src_o    = src_q;
  assign job_dst_o    = dst_q;
  assign job_len_o    = len_q;
  assign job_pnum_o   = pnum_q;
  assign dispatched_o = dispatched_q;
  assign completed_o  = completed_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_descriptor_dispatcher.sv
// tb/tb_descriptor_dispatcher.sv - self-checking bench for descriptor_dispatcher
module tb_descriptor_dispatcher;

  localparam int N = 4;

  typedef struct packed {
    logic [7:0]  opc;
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
    logic [8:0]  pnum;
  } job_t;

  logic          clk, rst_n, en, dsc_ready, dsc_pull, busy, err;
  logic [1023:0] dsc_data;
  logic [N-1:0]  job_valid, job_ready, eng_done;
  logic [7:0]    job_opcode;
  logic [63:0]   job_src, job_dst;
  logic [31:0]   job_len, dispatched, completed;
  logic [8:0]    job_pnum;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_pull_cyc = 0;
  logic pull_seen = 1'b0;
  logic [N-1:0] prev_valid = '0;

  logic [1023:0] fifo_q[$];
  job_t          exp_q[$];
  int            grants_q[$];
  int            acc_cyc_q[$];
  int            lat_q[$];
  job_t          mon_e;

  descriptor_dispatcher #(.NUM_ENGINES(N), .CNT_WIDTH(32), .OUT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en),
    .dsc_data_i(dsc_data), .dsc_ready_i(dsc_ready), .dsc_pull_o(dsc_pull),
    .job_valid_o(job_valid), .job_ready_i(job_ready),
    .job_opcode_o(job_opcode), .job_src_o(job_src), .job_dst_o(job_dst),
    .job_len_o(job_len), .job_pnum_o(job_pnum),
    .eng_done_i(eng_done), .dispatched_o(dispatched), .completed_o(completed),
    .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pops the head the cycle after a pull was observed.
  always @(posedge clk) begin
    #2;
    if (pull_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    dsc_ready = (fifo_q.size() != 0);
    dsc_data  = dsc_ready ? fifo_q[0] : '0;
  end

  // Monitor: one-hot offers, scoreboard compare of accepted jobs.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      pull_seen = dsc_pull;
      if (dsc_pull) last_pull_cyc = cyc;
      if (job_valid != '0 && prev_valid == '0) lat_q.push_back(cyc - last_pull_cyc);
      if (job_valid != '0) begin
        n_vec++;
        if ($countones(job_valid) != 1) begin
          n_bad++;
          $display("FAIL onehot: job_valid=%b, required exactly one bit", job_valid);
        end
      end
      if ((job_valid & job_ready) != '0) begin
        acc_cyc_q.push_back(cyc);
        for (int i = 0; i < N; i++) if (job_valid[i]) grants_q.push_back(i);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL accept: unexpected job opcode=%h, required no job", job_opcode);
        end else begin
          mon_e = exp_q.pop_front();
          if ({job_opcode, job_src, job_dst, job_len, job_pnum} !== mon_e) begin
            n_bad++;
            $display("FAIL fields: got opc=%h src=%h dst=%h len=%h pnum=%h, required opc=%h src=%h dst=%h len=%h pnum=%h",
                     job_opcode, job_src, job_dst, job_len, job_pnum,
                     mon_e.opc, mon_e.src, mon_e.dst, mon_e.len, mon_e.pnum);
          end
        end
      end
      prev_valid = job_valid;
    end else begin
      pull_seen  = 1'b0;
      prev_valid = '0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic push_desc(input logic [7:0] opc, input logic [63:0] src, input logic [63:0] dst,
                           input logic [31:0] len, input logic [8:0] pnum);
    logic [1023:0] d;
    bit dispatchable;
    d = '0;
    d[7:0] = opc; d[127:64] = src; d[191:128] = dst; d[223:192] = len; d[1000:992] = pnum;
    fifo_q.push_back(d);
    dispatchable = (opc != 8'h00);
`ifdef DISPATCH_ERR_CHECK_EN
    if (len == 32'd0) dispatchable = 1'b0;
`endif
    if (dispatchable) exp_q.push_back({opc, src, dst, len, pnum});
  endtask

  task automatic wait_grants(input int n, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (grants_q.size() >= n) ok = 1'b1;
      else at_neg();
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: got %0d grants, required %0d", name, grants_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; job_ready = '0; eng_done = '0;
    fifo_q.delete(); exp_q.delete(); grants_q.delete(); acc_cyc_q.delete(); lat_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Starts a pull with only mask ready, then drops readiness once the offer is up.
  task automatic hold_offer(input logic [N-1:0] mask);
    tick();
    en = 1'b1; job_ready = mask;
    tick(); tick();
    job_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; job_ready = '0; eng_done = '0;
    tick(); tick();
    at_neg();
    n_vec++; if (job_valid !== '0 || dsc_pull !== 1'b0) begin n_bad++;
      $display("FAIL reset_valid: valid=%b pull=%b, required 0", job_valid, dsc_pull); end
    n_vec++; if (dispatched !== 32'd0 || completed !== 32'd0) begin n_bad++;
      $display("FAIL reset_counters: disp=%0d comp=%0d, required 0", dispatched, completed); end
    n_vec++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++;
      $display("FAIL reset_flags: busy=%b err=%b, required 0", busy, err); end
    n_vec++; if ({job_opcode, job_src, job_dst, job_len, job_pnum} !== '0) begin n_bad++;
      $display("FAIL reset_fields: opc=%h len=%h, required 0", job_opcode, job_len); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    job_ready = 4'b1111; en = 1'b1;
    push_desc(8'h01, 64'h1000, 64'h2000, 32'h80, 9'd5);
    wait_grants(1, "single");
    n_vec++; if (grants_q.size() < 1 || grants_q[0] != 0) begin n_bad++;
      $display("FAIL single_grant: got %0d, required 0", grants_q.size() ? grants_q[0] : -1); end
    n_vec++; if (lat_q.size() < 1 || lat_q[0] != 2) begin n_bad++;
      $display("FAIL single_latency: got %0d, required 2", lat_q.size() ? lat_q[0] : -1); end
    tick(); at_neg();
    n_vec++; if (dispatched !== 32'd1 || completed !== 32'd0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL single_after_accept: disp=%0d comp=%0d busy=%b, required 1 0 1", dispatched, completed, busy); end
    tick(); eng_done = 4'b0001;
    tick(); eng_done = '0;
    at_neg();
    n_vec++; if (completed !== 32'd1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL single_done: comp=%0d busy=%b, required 1 0", completed, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    job_ready = 4'b1111; en = 1'b1;
    for (int i = 0; i < 8; i++)
      push_desc(8'h10 + 8'(i), 64'h4000 + 64'(i), 64'h8000 + 64'(i), 32'h40 + 32'(i), 9'(i));
    wait_grants(8, "b2b");
    for (int i = 0; i < 8 && i < grants_q.size(); i++) begin
      n_vec++; if (grants_q[i] != i % 4) begin n_bad++;
        $display("FAIL b2b_grant%0d: got %0d, required %0d", i, grants_q[i], i % 4); end
    end
    for (int i = 1; i < 8 && i < acc_cyc_q.size(); i++) begin
      n_vec++; if (acc_cyc_q[i] - acc_cyc_q[i-1] != 2) begin n_bad++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, required 2", i, acc_cyc_q[i] - acc_cyc_q[i-1]); end
    end
    tick(); at_neg();
    n_vec++; if (dispatched !== 32'd8) begin n_bad++;
      $display("FAIL b2b_dispatched: got %0d, required 8", dispatched); end
  endtask

  task automatic test_rr_ready();
    do_reset();
    en = 1'b1; job_ready = 4'b0100;
    push_desc(8'h21, 64'h1, 64'h2, 32'h10, 9'd1);
    wait_grants(1, "rr_only2");
    n_vec++; if (grants_q.size() < 1 || grants_q[0] != 2) begin n_bad++;
      $display("FAIL rr_only2: got %0d, required 2", grants_q.size() ? grants_q[0] : -1); end
    tick(); job_ready = 4'b1111;
    push_desc(8'h22, 64'h3, 64'h4, 32'h20, 9'd2);
    wait_grants(2, "rr_next");
    n_vec++; if (grants_q.size() < 2 || grants_q[1] != 3) begin n_bad++;
      $display("FAIL rr_next: got %0d, required 3", grants_q.size() > 1 ? grants_q[1] : -1); end
    tick(); job_ready = '0;
    push_desc(8'h23, 64'h5, 64'h6, 32'h30, 9'd3);
    for (int i = 0; i < 6; i++) begin
      at_neg();
      n_vec++; if (job_valid !== '0) begin n_bad++;
        $display("FAIL rr_hold%0d: valid=%b, required 0000", i, job_valid); end
    end
    job_ready = 4'b0010;
    wait_grants(3, "rr_late");
    n_vec++; if (grants_q.size() < 3 || grants_q[2] != 1) begin n_bad++;
      $display("FAIL rr_late: got %0d, required 1", grants_q.size() > 2 ? grants_q[2] : -1); end
    tick();
  endtask

  task automatic test_nop_and_done();
    bit seen;
    do_reset();
    job_ready = 4'b1111; en = 1'b1;
    push_desc(8'h31, 64'hA, 64'hB, 32'h11, 9'd7);
    push_desc(8'h00, 64'hC, 64'hD, 32'h22, 9'd8);
    push_desc(8'h32, 64'hE, 64'hF, 32'h33, 9'd9);
    wait_grants(2, "nop");
    repeat (4) tick();
    at_neg();
    n_vec++; if (dispatched !== 32'd2 || fifo_q.size() != 0) begin n_bad++;
      $display("FAIL nop_drop: disp=%0d fifo_left=%0d, required 2 0", dispatched, fifo_q.size()); end
    n_vec++; if (grants_q.size() < 2 || grants_q[1] != 1) begin n_bad++;
      $display("FAIL nop_rr: got %0d, required 1", grants_q.size() > 1 ? grants_q[1] : -1); end
    push_desc(8'h33, 64'h10, 64'h20, 32'h44, 9'd10);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      at_neg();
      if (job_valid != '0) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++;
      $display("FAIL net_offer_timeout: valid=%b, required an offer", job_valid); end
    eng_done = 4'b1001;
    tick(); eng_done = '0;
    at_neg();
    n_vec++; if (completed !== 32'd2 || dispatched !== 32'd3 || busy !== 1'b1) begin n_bad++;
      $display("FAIL net_accept_done: comp=%0d disp=%0d busy=%b, required 2 3 1", completed, dispatched, busy); end
    tick(); eng_done = 4'b0100;
    tick(); eng_done = '0;
    at_neg();
    n_vec++; if (completed !== 32'd3 || busy !== 1'b0) begin n_bad++;
      $display("FAIL net_drain: comp=%0d busy=%b, required 3 0", completed, busy); end
  endtask

  task automatic test_enable_and_reset();
    do_reset();
    en = 1'b0; job_ready = '0;
    push_desc(8'h41, 64'h100, 64'h200, 32'h55, 9'd11);
    for (int i = 0; i < 5; i++) begin
      at_neg();
      n_vec++; if (dsc_pull !== 1'b0) begin n_bad++;
        $display("FAIL en_low_pull%0d: pull=%b, required 0", i, dsc_pull); end
    end
    hold_offer(4'b0001);
    en = 1'b0;
    push_desc(8'h42, 64'h300, 64'h400, 32'h66, 9'd12);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      n_vec++; if (job_valid !== 4'b0001 || dsc_pull !== 1'b0) begin n_bad++;
        $display("FAIL en_drop_hold%0d: valid=%b pull=%b, required 0001 0", i, job_valid, dsc_pull); end
    end
    job_ready = 4'b1111;
    tick(); job_ready = '0;
    at_neg();
    n_vec++; if (dispatched !== 32'd1 || job_valid !== '0 || dsc_pull !== 1'b0) begin n_bad++;
      $display("FAIL en_drop_accept: disp=%0d valid=%b pull=%b, required 1 0000 0", dispatched, job_valid, dsc_pull); end
    hold_offer(4'b0010);
    at_neg();
    n_vec++; if (job_valid !== 4'b0010) begin n_bad++;
      $display("FAIL rst_pre_offer: valid=%b, required 0010", job_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (job_valid !== '0 || dispatched !== 32'd0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_in_offer: valid=%b disp=%0d busy=%b, required 0000 0 0", job_valid, dispatched, busy); end
    do_reset();
  endtask

  task automatic test_err_check();
    do_reset();
    job_ready = 4'b1111; en = 1'b1;
    push_desc(8'h51, 64'h500, 64'h600, 32'h0, 9'd13);
`ifdef DISPATCH_ERR_CHECK_EN
    repeat (8) at_neg();
    n_vec++; if (err !== 1'b1 || dispatched !== 32'd0 || grants_q.size() != 0) begin n_bad++;
      $display("FAIL err_drop: err=%b disp=%0d grants=%0d, required 1 0 0", err, dispatched, grants_q.size()); end
`else
    wait_grants(1, "err_off");
    tick(); at_neg();
    n_vec++; if (err !== 1'b0 || dispatched !== 32'd1) begin n_bad++;
      $display("FAIL err_off: err=%b disp=%0d, required 0 1", err, dispatched); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; job_ready = '0; eng_done = '0;
    dsc_ready = 1'b0; dsc_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_ready();
    test_nop_and_done();
    test_enable_and_reset();
    test_err_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/descriptor_dispatcher.md
Name: descriptor_dispatcher

Overview:
- Consumes 1024-bit job descriptors from the descriptor FIFO read port produced by the descriptor fetch stage, and parses each one into job fields.
- Issues each job to one of NUM_ENGINES processing engines using round-robin selection among ready engines.
- Tracks outstanding jobs via engine done pulses; exposes counters and a busy flag to the action register layer.

Parameters:
NUM_ENGINES, 4, number of downstream engines (2..8)
CNT_WIDTH, 32, width of dispatched/completed counters
OUT_WIDTH, 16, width of outstanding-job counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en_i  in  1  dispatch enable; low stops new descriptor pulls
dsc_data_i  in  1024  descriptor at FIFO head (first-word-fall-through)
dsc_ready_i  in  1  FIFO non-empty; dsc_data_i valid
dsc_pull_o  out  1  pop FIFO head this cycle
job_valid_o  out  NUM_ENGINES  one-hot job offer
job_ready_i  in  NUM_ENGINES  engine can accept; must not depend on job_valid_o
job_opcode_o  out  8  descriptor [7:0]
job_src_o  out  64  descriptor [127:64]
job_dst_o  out  64  descriptor [191:128]
job_len_o  out  32  byte length, descriptor [223:192]
job_pnum_o  out  9  process number, descriptor [1000:992]
eng_done_i  in  NUM_ENGINES  one-cycle completion pulse per engine
dispatched_o  out  CNT_WIDTH  jobs accepted by engines
completed_o  out  CNT_WIDTH  done pulses counted
busy_o  out  1  staging occupied or outstanding != 0
err_o  out  1  sticky descriptor error (optional feature only; else 0)

Behaviour:
- Reset: all outputs 0; FSM EMPTY; rr_ptr=0; counters 0.
- FSM states:
  - EMPTY: dsc_pull_o = en_i & dsc_ready_i (combinational). On pull, latch dsc_data_i into staging register -> SELECT.
  - SELECT: if opcode==8'h00 (NOP), drop: no offer and no count change -> EMPTY. Else scan job_ready_i starting at rr_ptr, wrapping modulo NUM_ENGINES. First ready index k becomes the grant; job_valid_o[k] is registered high next cycle -> OFFER. No engine ready: stay in SELECT and rescan each cycle.
  - OFFER: job_valid_o holds one-hot k and job fields stay stable until job_ready_i[k]. On acceptance: dispatched_o+1, outstanding+1, rr_ptr=(k+1) mod NUM_ENGINES, job_valid_o cleared. Same cycle, if en_i & dsc_ready_i, pull and reload -> SELECT; else -> EMPTY.
- A granted offer is never withdrawn or retargeted; deasserting en_i does not cancel it.
- Latency: pull at t, job_valid_o at t+2 at earliest. Peak throughput is 1 job per 2 cycles.
- Completion: completed_o += popcount(eng_done_i) each cycle.
  - outstanding += accept - popcount(eng_done_i) in the same cycle; simultaneous accept and done nets out correctly.
  - Outstanding saturates at 0 on surplus done pulses (never underflows) and at all-ones on overflow.
- dispatched_o and completed_o wrap modulo 2^CNT_WIDTH.
- busy_o = (state!=EMPTY) | (outstanding!=0), registered.
- Reset mid-operation: staged descriptor is discarded and any offer is withdrawn immediately (async). The FIFO is reset by the same rst_n, so nothing is lost silently.

Optional Feature:
- Macro DISPATCH_ERR_CHECK_EN.
- Defined: in SELECT, a non-NOP descriptor is treated as an error if job_len==0 or bits [1023:1001]!=0. An error descriptor is dropped like a NOP, sets err_o (sticky until reset), and increments no counters.
- Undefined: no check, err_o tied 0, and such descriptors are dispatched normally.

Decomposition:
- Package dispatcher_pkg holds:
  - descriptor field bit-position constants (OPC, SRC, DST, LEN, PNUM lsb/msb);
  - NOP opcode constant;
  - FSM state encoding typedef {EMPTY, SELECT, OFFER}.
- One sub-module, rr_pick: combinational round-robin priority selector (ready vector and start pointer in, one-hot grant and found flag out). It is reused by other arbiters in the design.

Test Plan:
- Single descriptor: opcode 8'h01, src 0x1000, dst 0x2000, len 0x80, pnum 5; all engines ready. Expect job_valid_o=4'b0001 two cycles after pull, correct fields, dispatched_o=1, busy_o=1 until eng_done_i[0], then completed_o=1 and busy_o=0.
- Eight back-to-back descriptors, all engines ready: grants go 0,1,2,3,0,1,2,3; one accept every 2 cycles; dispatched_o=8.
- Only engine 2 ready with rr_ptr=0: grant 2, next rr_ptr=3. With all engines not ready, SELECT holds and valid stays 0 until engine 1 rises; then grant 1.
- NOP descriptor between two valid ones: the NOP is pulled and dropped, dispatched_o=2. Done pulses on engines 0 and 3 in the same cycle as an accept: outstanding net +1-2.
- en_i low while FIFO is non-empty: dsc_pull_o stays 0. With en_i dropped during OFFER, the offer still completes. rst_n asserted in OFFER: job_valid_o=0 immediately and counters=0.
- With DISPATCH_ERR_CHECK_EN: descriptor with len=0 -> dropped, err_o=1, dispatched_o unchanged. Without the macro the same descriptor is dispatched and err_o stays 0.
